// File: rtl/add_operand_pair_pkg.sv
// Constants shared by the operand-issue block and the FP16 ADD stage.
package add_operand_pair_pkg;

    localparam int unsigned FP16_W         = 16;
    localparam int unsigned INFO_W_DEFAULT = 23;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO with read pointer plus occupancy count. The head entry is
// presented combinationally. Write and read may happen together, even when full.
module operand_fifo #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write slot wraps modulo DEPTH; when full with a pop, it is the slot being read.
    assign wr_ptr  = rd_ptr_q + count_q[PTR_W-1:0];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign head_o  = mem_q[rd_ptr_q];

    // Next read pointer and occupancy from this cycle's write/read pair.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_en_i && !rd_en_i) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en_i && !wr_en_i) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while count is zero.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr] <= wr_data_i;
        end
    end

endmodule

// File: rtl/add_operand_pair.sv
// Pairs two independently timed FP16 operand streams and issues one registered
// operand pair per cycle toward the ADD stage whenever both FIFOs hold data.
module add_operand_pair
    import add_operand_pair_pkg::*;
#(
    parameter int unsigned INFO_WIDTH = INFO_W_DEFAULT,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_vld,
    input  logic [FP16_W-1:0]     a_data,
    input  logic [INFO_WIDTH-1:0] a_info,
    output logic                  a_rdy,
    input  logic                  b_vld,
    input  logic [FP16_W-1:0]     b_data,
    input  logic [INFO_WIDTH-1:0] b_info,
    output logic                  b_rdy,
    output logic                  in_vld,
    output logic [FP16_W-1:0]     data0,
    output logic [FP16_W-1:0]     data1,
    output logic [INFO_WIDTH-1:0] info_in,
    output logic                  err_ovf,
    output logic                  err_info
);

    localparam int unsigned ENTRY_W = FP16_W + INFO_WIDTH;

    logic               a_empty, a_full, b_empty, b_full;
    logic [ENTRY_W-1:0] a_head, b_head;
    logic               pop, a_wr, b_wr;

    logic                  in_vld_q, in_vld_d;
    logic [FP16_W-1:0]     data0_q, data0_d;
    logic [FP16_W-1:0]     data1_q, data1_d;
    logic [INFO_WIDTH-1:0] info_q, info_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_info_q, err_info_d;

    // A full FIFO still accepts a write in a cycle where it is also popped.
    assign pop   = !a_empty && !b_empty;
    assign a_wr  = a_vld && (!a_full || pop);
    assign b_wr  = b_vld && (!b_full || pop);
    assign a_rdy = !a_full;
    assign b_rdy = !b_full;

    operand_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (a_wr),
        .wr_data_i ({a_data, a_info}),
        .rd_en_i   (pop),
        .empty_o   (a_empty),
        .full_o    (a_full),
        .head_o    (a_head)
    );

    operand_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (b_wr),
        .wr_data_i ({b_data, b_info}),
        .rd_en_i   (pop),
        .empty_o   (b_empty),
        .full_o    (b_full),
        .head_o    (b_head)
    );

    // Load the output pair on a pop and accumulate the sticky error flags.
    always_comb begin
        in_vld_d   = 1'b0;
        data0_d    = data0_q;
        data1_d    = data1_q;
        info_d     = info_q;
        err_info_d = err_info_q;
        err_ovf_d  = err_ovf_q | (a_vld & ~a_wr) | (b_vld & ~b_wr);
        if (pop) begin
            in_vld_d = 1'b1;
            data0_d  = a_head[ENTRY_W-1:INFO_WIDTH];
            data1_d  = b_head[ENTRY_W-1:INFO_WIDTH];
            info_d   = a_head[INFO_WIDTH-1:0];
            if (a_head[INFO_WIDTH-1:0] != b_head[INFO_WIDTH-1:0]) begin
                err_info_d = 1'b1;
            end
        end
    end

    // Output and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vld_q   <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            info_q     <= '0;
            err_ovf_q  <= 1'b0;
            err_info_q <= 1'b0;
        end else begin
            in_vld_q   <= in_vld_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            info_q     <= info_d;
            err_ovf_q  <= err_ovf_d;
            err_info_q <= err_info_d;
        end
    end

    assign in_vld   = in_vld_q;
    assign data0    = data0_q;
    assign data1    = data1_q;
    assign info_in  = info_q;
    assign err_ovf  = err_ovf_q;
    assign err_info = err_info_q;

endmodule

// File: tb/tb_add_operand_pair.sv
// Self-checking bench for add_operand_pair: a queue-level reference model of
// both FIFOs pushes expected pairs into a scoreboard, and each scenario task
// compares the DUT output stream plus scenario-specific constants inline.
module tb_add_operand_pair;

    localparam int IW    = 23;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0]   d0;
        logic [15:0]   d1;
        logic [IW-1:0] info;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_vld = 1'b0, b_vld = 1'b0;
    logic [15:0]   a_data = '0, b_data = '0;
    logic [IW-1:0] a_info = '0, b_info = '0;
    logic          a_rdy, b_rdy, in_vld, err_ovf, err_info;
    logic [15:0]   data0, data1;
    logic [IW-1:0] info_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15+IW:0] ma_q[$];
    logic [15+IW:0] mb_q[$];
    pair_t          exp_q[$];

    add_operand_pair #(.INFO_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_vld(a_vld), .a_data(a_data), .a_info(a_info), .a_rdy(a_rdy),
        .b_vld(b_vld), .b_data(b_data), .b_info(b_info), .b_rdy(b_rdy),
        .in_vld(in_vld), .data0(data0), .data1(data1), .info_in(info_in),
        .err_ovf(err_ovf), .err_info(err_info)
    );

    always #5 clk = ~clk;

    // Reference model: pop decided on start-of-cycle occupancy, then writes.
    always @(posedge clk or posedge rst) begin
        int na, nb;
        bit mpop;
        logic [15+IW:0] ha, hb;
        if (rst) begin
            ma_q.delete(); mb_q.delete(); exp_q.delete();
        end else begin
            na = ma_q.size(); nb = mb_q.size();
            mpop = (na > 0) && (nb > 0);
            if (mpop) begin
                ha = ma_q.pop_front();
                hb = mb_q.pop_front();
                exp_q.push_back({ha[15+IW:IW], hb[15+IW:IW], ha[IW-1:0]});
            end
            if (a_vld && (na < DEPTH || mpop)) ma_q.push_back({a_data, a_info});
            if (b_vld && (nb < DEPTH || mpop)) mb_q.push_back({b_data, b_info});
        end
    end

    task automatic drive(input logic av, input logic [15:0] ad, input logic [IW-1:0] ai,
                         input logic bv, input logic [15:0] bd, input logic [IW-1:0] bi);
        a_vld = av; a_data = ad; a_info = ai;
        b_vld = bv; b_data = bd; b_info = bi;
    endtask

    task automatic idle();
        a_vld = 1'b0; b_vld = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (in_vld !== 1'b0)  begin n_fail++; $display("FAIL reset_in_vld got %b want 0", in_vld); end
        n_checks++; if (data0 !== 16'h0)  begin n_fail++; $display("FAIL reset_data0 got %h want 0", data0); end
        n_checks++; if (data1 !== 16'h0)  begin n_fail++; $display("FAIL reset_data1 got %h want 0", data1); end
        n_checks++; if (info_in !== '0)   begin n_fail++; $display("FAIL reset_info got %h want 0", info_in); end
        n_checks++; if (err_ovf !== 1'b0 || err_info !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", err_ovf, err_info); end
        n_checks++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b%b want 11", a_rdy, b_rdy); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_vld !== 1'b0) begin n_fail++; $display("FAIL post_reset_in_vld got %b want 0", in_vld); end
    endtask

    task automatic test_same_cycle();
        pair_t want;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(1'b1, 16'h3C00, 23'd5, 1'b1, 16'h4000, 23'd5); else idle();
            @(posedge clk); #1;
            n_checks++;
            if (in_vld !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL same_sb_vld c=%0d got %b want %b", c, in_vld, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (in_vld === 1'b1) begin n_checks++; if ({data0, data1, info_in} !== want) begin n_fail++; $display("FAIL same_sb_pair got %h want %h", {data0, data1, info_in}, want); end end
            end
            n_checks++; if (in_vld !== (c == 1)) begin n_fail++; $display("FAIL same_latency c=%0d got %b want %b", c, in_vld, c == 1); end
            if (c == 1) begin
                n_checks++; if ({data0, data1, info_in} !== {16'h3C00, 16'h4000, 23'd5}) begin n_fail++; $display("FAIL same_pair got %h/%h/%0d want 3c00/4000/5", data0, data1, info_in); end
            end
            n_checks++; if (err_ovf !== 1'b0 || err_info !== 1'b0) begin n_fail++; $display("FAIL same_err got %b%b want 00", err_ovf, err_info); end
        end
    endtask

    task automatic test_skewed();
        pair_t want;
        logic [15:0] bd [4];
        int first, npairs;
        bd[0] = 16'h7C00; bd[1] = 16'h7E01; bd[2] = 16'h0001; bd[3] = 16'h8000;
        first = -1; npairs = 0;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            idle();
            if (c < 4) begin a_vld = 1'b1; a_data = 16'h1000 + 16'(c); a_info = 23'(c + 10); end
            if (c >= 10 && c < 14) begin b_vld = 1'b1; b_data = bd[c-10]; b_info = 23'(c);  end
            @(posedge clk); #1;
            n_checks++;
            if (in_vld !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL skew_sb_vld c=%0d got %b want %b", c, in_vld, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (in_vld === 1'b1) begin n_checks++; if ({data0, data1, info_in} !== want) begin n_fail++; $display("FAIL skew_sb_pair got %h want %h", {data0, data1, info_in}, want); end end
            end
            if (in_vld === 1'b1) begin npairs++; if (first < 0) first = c; end
        end
        n_checks++; if (first != 11 || npairs != 4) begin n_fail++; $display("FAIL skew_timing got first=%0d n=%0d want first=11 n=4", first, npairs); end
        n_checks++; if (data1 !== 16'h8000 || data0 !== 16'h1003) begin n_fail++; $display("FAIL skew_last got %h/%h want 1003/8000", data0, data1); end
        n_checks++; if (err_info !== 1'b0) begin n_fail++; $display("FAIL skew_err_info got %b want 0", err_info); end
    endtask

    task automatic test_overflow();
        pair_t want;
        int npairs;
        npairs = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c < 5) begin a_vld = 1'b1; a_data = 16'h2000 + 16'(c); a_info = 23'(20 + c); end
            if (c >= 5 && c < 9) begin b_vld = 1'b1; b_data = 16'h5000 + 16'(c); b_info = 23'(15 + c); end
            if (c == 3) begin n_checks++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL ovf_rdy3 got %b want 1", a_rdy); end end
            if (c == 4) begin n_checks++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy4 got %b want 0", a_rdy); end end
            @(posedge clk); #1;
            if (c == 3) begin n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", err_ovf); end end
            if (c == 4) begin n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", err_ovf); end end
            n_checks++;
            if (in_vld !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL ovf_sb_vld c=%0d got %b want %b", c, in_vld, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (in_vld === 1'b1) begin n_checks++; if ({data0, data1, info_in} !== want) begin n_fail++; $display("FAIL ovf_sb_pair got %h want %h", {data0, data1, info_in}, want); end end
            end
            if (in_vld === 1'b1) npairs++;
        end
        n_checks++; if (npairs != 4 || data0 !== 16'h2003) begin n_fail++; $display("FAIL ovf_pairs got n=%0d last=%h want n=4 last=2003", npairs, data0); end
        n_checks++; if (err_ovf !== 1'b1 || err_info !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky got %b%b want 10", err_ovf, err_info); end
    endtask

    task automatic test_tag_mismatch();
        pair_t want;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(1'b1, 16'h1234, 23'd7, 1'b1, 16'h5678, 23'd8); else idle();
            @(posedge clk); #1;
            n_checks++;
            if (in_vld !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL tag_sb_vld c=%0d got %b want %b", c, in_vld, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (in_vld === 1'b1) begin n_checks++; if ({data0, data1, info_in} !== want) begin n_fail++; $display("FAIL tag_sb_pair got %h want %h", {data0, data1, info_in}, want); end end
            end
            n_checks++; if (err_info !== (c >= 1)) begin n_fail++; $display("FAIL tag_err_info c=%0d got %b want %b", c, err_info, c >= 1); end
            if (c == 1) begin
                n_checks++; if (in_vld !== 1'b1 || info_in !== 23'd7) begin n_fail++; $display("FAIL tag_issue got vld=%b info=%0d want vld=1 info=7", in_vld, info_in); end
            end
        end
    endtask

    task automatic test_full_write_pop();
        pair_t want;
        int npairs;
        npairs = 0;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            idle();
            if (c < 4 || c == 5) begin a_vld = 1'b1; a_data = 16'h6000 + 16'(c < 4 ? c : 4); a_info = 23'(40 + (c < 4 ? c : 4)); end
            if (c >= 4 && c != 5 && c < 10) begin b_vld = 1'b1; b_data = 16'h7000 + 16'(c == 4 ? 0 : c - 5); b_info = 23'(40 + (c == 4 ? 0 : c - 5)); end
            if (c == 5) begin n_checks++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy_before got %b want 0", a_rdy); end end
            @(posedge clk); #1;
            if (c == 5) begin
                n_checks++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL full_count_kept got rdy=%b want 0", a_rdy); end
                n_checks++; if (in_vld !== 1'b1 || data0 !== 16'h6000) begin n_fail++; $display("FAIL full_pop got %b/%h want 1/6000", in_vld, data0); end
            end
            n_checks++;
            if (in_vld !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL full_sb_vld c=%0d got %b want %b", c, in_vld, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (in_vld === 1'b1) begin n_checks++; if ({data0, data1, info_in} !== want) begin n_fail++; $display("FAIL full_sb_pair got %h want %h", {data0, data1, info_in}, want); end end
            end
            if (in_vld === 1'b1) npairs++;
        end
        n_checks++; if (npairs != 5 || data0 !== 16'h6004 || data1 !== 16'h7004) begin n_fail++; $display("FAIL full_pairs got n=%0d last=%h/%h want n=5 last=6004/7004", npairs, data0, data1); end
        n_checks++; if (err_ovf !== 1'b0 || err_info !== 1'b0) begin n_fail++; $display("FAIL full_err got %b%b want 00", err_ovf, err_info); end
    endtask

    task automatic test_reset_mid();
        pair_t want;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c == 0) drive(1'b1, 16'h0AAA, 23'd1, 1'b1, 16'h0BBB, 23'd1);
            else begin a_vld = 1'b1; a_data = 16'h0A00 + 16'(c); a_info = 23'(c + 1); end
            @(posedge clk); #1;
        end
        idle();
        n_checks++; if (data0 !== 16'h0AAA) begin n_fail++; $display("FAIL rmid_pre got %h want 0aaa", data0); end
        rst = 1'b1; #1;
        n_checks++; if ({in_vld, data0, data1, info_in, err_ovf, err_info} !== '0) begin n_fail++; $display("FAIL rmid_outs got %b/%h/%h/%h/%b%b want all 0", in_vld, data0, data1, info_in, err_ovf, err_info); end
        n_checks++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_rdy got %b%b want 11", a_rdy, b_rdy); end
        #1; rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 3)  begin b_vld = 1'b1; b_data = 16'h0B10 + 16'(c); b_info = 23'd9; end
            if (c == 3) begin a_vld = 1'b1; a_data = 16'h0A10; a_info = 23'd9; end
            @(posedge clk); #1;
            n_checks++; if (in_vld !== (c == 4)) begin n_fail++; $display("FAIL rmid_vld c=%0d got %b want %b", c, in_vld, c == 4); end
            if (c == 4) begin n_checks++; if (data0 !== 16'h0A10 || data1 !== 16'h0B10) begin n_fail++; $display("FAIL rmid_pair got %h/%h want 0a10/0b10", data0, data1); end end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (in_vld === 1'b1) begin n_checks++; if ({data0, data1, info_in} !== want) begin n_fail++; $display("FAIL rmid_sb_pair got %h want %h", {data0, data1, info_in}, want); end end
            end
        end
    endtask

    task automatic test_back_to_back();
        pair_t want;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            idle();
            if (c < 8) drive(1'b1, 16'h3000 + 16'(c), 23'(100 + c), 1'b1, 16'hFC00 + 16'(c), 23'(100 + c));
            @(posedge clk); #1;
            n_checks++; if (in_vld !== (c >= 1 && c <= 8)) begin n_fail++; $display("FAIL b2b_vld c=%0d got %b want %b", c, in_vld, c >= 1 && c <= 8); end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (in_vld === 1'b1) begin n_checks++; if ({data0, data1, info_in} !== want) begin n_fail++; $display("FAIL b2b_sb_pair got %h want %h", {data0, data1, info_in}, want); end end
            end
        end
        n_checks++; if (data0 !== 16'h3007 || data1 !== 16'hFC07) begin n_fail++; $display("FAIL b2b_last got %h/%h want 3007/fc07", data0, data1); end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_skewed();
        test_overflow();
        test_tag_mismatch();
        test_full_write_pop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
